// File: rtl/clk_div_bank.sv
// Bank of NCH programmable clock dividers with per-channel period/high-time and enable.
// Latency: tick/clk_out are registered and reflect the count loaded on the same clk_in edge.
// Backpressure: none; configuration writes are always accepted and wr_ch >= NCH is dropped.
// Optional macro CLK_DIV_BANK_SYNC_EN compiles in the sync_req restart of all enabled channels.
module clk_div_bank #(
    parameter int NCH     = 2,
    parameter int CNT_W   = 26,
    parameter int DEF_DIV = 5000000,
    localparam int WCH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [NCH-1:0]   en,
    input  logic             wr_en,
    input  logic [WCH_W-1:0] wr_ch,
    input  logic             wr_sel,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             sync_req,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick
);

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_DIV >> 1);

    // Host-visible shadow settings, in-use active settings and the period counter.
    logic [CNT_W-1:0] sh_p [NCH];
    logic [CNT_W-1:0] sh_h [NCH];
    logic [CNT_W-1:0] ac_p [NCH];
    logic [CNT_W-1:0] ac_h [NCH];
    logic [CNT_W-1:0] cnt  [NCH];
    logic [NCH-1:0]   running;

    // Next-state helpers.
    logic [CNT_W-1:0] peff_m1 [NCH];
    logic [CNT_W-1:0] cnt_nxt [NCH];
    logic [CNT_W-1:0] h_nxt   [NCH];
    logic [NCH-1:0]   start;
    logic [NCH-1:0]   wr_hit;
    logic             sync_go;

`ifdef CLK_DIV_BANK_SYNC_EN
    assign sync_go = sync_req;
`else
    // Restart feature compiled out: the port stays but drives nothing.
    logic unused_sync;
    assign unused_sync = sync_req;
    assign sync_go     = 1'b0;
`endif

    // Period-start detection and next count / next high time per channel.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            peff_m1[i] = '0;
            cnt_nxt[i] = '0;
            h_nxt[i]   = '0;
            start[i]   = 1'b0;
            wr_hit[i]  = 1'b0;
            // Periods below 2 are stretched to 2 so clk_out can still toggle.
            peff_m1[i] = (ac_p[i] < CNT_W'(2)) ? CNT_W'(1) : ac_p[i] - CNT_W'(1);
            start[i]   = en[i] & (sync_go | ~running[i] | (cnt[i] >= peff_m1[i]));
            cnt_nxt[i] = start[i] ? '0 : cnt[i] + CNT_W'(1);
            // On a period start the shadow H becomes active on this same edge.
            h_nxt[i]   = start[i] ? sh_h[i] : ac_h[i];
            wr_hit[i]  = wr_en & (int'(wr_ch) == i);
        end
    end

    // Per-channel state update; reads of sh_* see the pre-write value, so a
    // write coinciding with a period start only lands at the next one.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                sh_p[i]    <= DEF_P;
                sh_h[i]    <= DEF_H;
                ac_p[i]    <= DEF_P;
                ac_h[i]    <= DEF_H;
                cnt[i]     <= '0;
                running[i] <= 1'b0;
                clk_out[i] <= 1'b0;
                tick[i]    <= 1'b0;
            end else begin
                if (wr_hit[i] && !wr_sel) begin
                    sh_p[i] <= wr_data;
                end
                if (wr_hit[i] && wr_sel) begin
                    sh_h[i] <= wr_data;
                end
                if (!en[i]) begin
                    cnt[i]     <= '0;
                    running[i] <= 1'b0;
                    clk_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                    ac_p[i]    <= sh_p[i];
                    ac_h[i]    <= sh_h[i];
                end else begin
                    cnt[i]     <= cnt_nxt[i];
                    running[i] <= 1'b1;
                    tick[i]    <= start[i];
                    clk_out[i] <= (cnt_nxt[i] < h_nxt[i]);
                    if (start[i]) begin
                        ac_p[i] <= sh_p[i];
                        ac_h[i] <= sh_h[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank (NCH=2, CNT_W=8, DEF_DIV=10).
// Expected outputs come from hand-tracked counts per channel.
// Outputs are sampled 1 time unit after each rising edge.
module tb_clk_div_bank;

    logic       clk_in = 1'b0;
    logic       reset;
    logic [1:0] en;
    logic       wr_en;
    logic [0:0] wr_ch;
    logic       wr_sel;
    logic [7:0] wr_data;
    logic       sync_req;
    logic [1:0] clk_out;
    logic [1:0] tick;

    int checks = 0;
    int errors = 0;
    int s0;
    int s1;

    clk_div_bank #(.NCH(2), .CNT_W(8), .DEF_DIV(10)) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .en       (en),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .sync_req (sync_req),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always #5 clk_in = ~clk_in;

    // c<0 marks a disabled channel (both outputs low).
    function automatic logic [1:0] exp_tick(input int c0, input int c1);
        return {c1 == 0, c0 == 0};
    endfunction

    function automatic logic [1:0] exp_clk(input int c0, input int h0, input int c1, input int h1);
        return {(c1 >= 0) && (c1 < h1), (c0 >= 0) && (c0 < h0)};
    endfunction

    // Advance one edge, then compare against the expected count of each channel.
    task automatic step(input int c0, input int h0, input int c1, input int h1, input string tag);
        logic [1:0] et;
        logic [1:0] ec;
        @(posedge clk_in);
        #1;
        et = exp_tick(c0, c1);
        ec = exp_clk(c0, h0, c1, h1);
        checks++;
        assert (tick === et) else begin
            errors++;
            $error("FAIL %s tick observed=%b expected=%b", tag, tick, et);
        end
        checks++;
        assert (clk_out === ec) else begin
            errors++;
            $error("FAIL %s clk_out observed=%b expected=%b", tag, clk_out, ec);
        end
    endtask

    initial begin
        reset    = 1'b1;
        en       = 2'b00;
        wr_en    = 1'b0;
        wr_ch    = 1'b0;
        wr_sel   = 1'b0;
        wr_data  = 8'd0;
        sync_req = 1'b0;
        step(-1, 0, -1, 0, "reset");

        // Default divide-by-10, 5 high / 5 low on ch0; ch1 idle.
        reset = 1'b0;
        en    = 2'b01;
        for (int k = 0; k < 24; k++) step(k % 10, 5, -1, 0, "default_div");

        // ch0 now at count 3: write P=4 then H=1; current period finishes first.
        wr_en = 1'b1; wr_ch = 1'b0; wr_sel = 1'b0; wr_data = 8'd4;
        step(4, 5, -1, 0, "write_p4");
        wr_sel = 1'b1; wr_data = 8'd1;
        step(5, 5, -1, 0, "write_h1");
        wr_en = 1'b0;
        for (int c = 6; c < 10; c++) step(c, 5, -1, 0, "finish_old_period");
        for (int j = 0; j < 8; j++) step(j % 4, 1, -1, 0, "period4_high1");

        // Write P=10 on a period-start edge: old shadow (P=4,H=1) is loaded.
        wr_en = 1'b1; wr_sel = 1'b0; wr_data = 8'd10;
        step(0, 1, -1, 0, "write_on_start");
        wr_sel = 1'b1; wr_data = 8'd0;
        step(1, 1, -1, 0, "write_h0");
        wr_en = 1'b0;
        step(2, 1, -1, 0, "last_p4_a");
        step(3, 1, -1, 0, "last_p4_b");
        for (int j = 0; j < 9; j++) step(j, 0, -1, 0, "h0_always_low");

        // H=12 exceeds the period: clk_out stays high, tick still every 10.
        wr_en = 1'b1; wr_sel = 1'b1; wr_data = 8'd12;
        step(9, 0, -1, 0, "write_h12");
        wr_en = 1'b0;
        for (int j = 0; j < 20; j++) step(j % 10, 12, -1, 0, "h12_always_high");

        // P=1, H=1: effective period 2, toggling every cycle.
        wr_en = 1'b1; wr_sel = 1'b0; wr_data = 8'd1;
        step(0, 12, -1, 0, "write_p1");
        wr_sel = 1'b1; wr_data = 8'd1;
        step(1, 12, -1, 0, "write_h1_again");
        wr_en = 1'b0;
        for (int c = 2; c < 10; c++) step(c, 12, -1, 0, "drain_h12");
        for (int j = 0; j < 8; j++) step(j % 2, 1, -1, 0, "peff2_toggle");

        // Restore P=10, H=5.
        wr_en = 1'b1; wr_sel = 1'b0; wr_data = 8'd10;
        step(0, 1, -1, 0, "restore_p");
        wr_sel = 1'b1; wr_data = 8'd5;
        step(1, 1, -1, 0, "restore_h");
        wr_en = 1'b0;
        for (int c = 0; c < 7; c++) step(c, 5, -1, 0, "restored");

        // Drop enable at count 6, then re-enable for a fresh full period.
        en = 2'b00;
        step(-1, 0, -1, 0, "disable");
        step(-1, 0, -1, 0, "disabled_hold");
        en = 2'b01;
        for (int j = 0; j < 11; j++) step(j % 10, 5, -1, 0, "reenable");
        for (int c = 1; c < 5; c++) step(c, 5, -1, 0, "pre_ch1");

        // Start ch1 while ch0 is at 5, giving ch0=2 / ch1=7 seven edges later.
        en = 2'b11;
        step(5, 5, 0, 5, "ch1_start");
        for (int j = 1; j < 8; j++) step((5 + j) % 10, 5, j, 5, "two_channels");

        sync_req = 1'b1;
`ifdef CLK_DIV_BANK_SYNC_EN
        s0 = 0; s1 = 0;
`else
        s0 = 3; s1 = 8;
`endif
        step(s0, 5, s1, 5, "sync_edge");
        sync_req = 1'b0;
        for (int j = 1; j < 13; j++) step((s0 + j) % 10, 5, (s1 + j) % 10, 5, "post_sync");

        // Reset mid-period overrides en; both channels restart with defaults.
        reset = 1'b1;
        step(-1, 0, -1, 0, "mid_reset");
        reset = 1'b0;
        for (int j = 0; j < 11; j++) step(j % 10, 5, j % 10, 5, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
